// File: rtl/host_mem_arb.sv
// Round-robin arbiter: NUM_REQ requesters share one host-memory port, with burst lock, read-return routing and MSI-X doorbell snoop.
// Latency: 1-cycle arbitration bubble (IDLE) before each burst; mem_* and rsp_* are combinational from owner regs / inputs.
// Backpressure: i_mem_ready is forwarded only to the owner's o_req_ready; the owner keeps the lock until its last beat is accepted.
module host_mem_arb #(
    parameter int                  NUM_REQ   = 4,
    parameter int                  ADDR_W    = 64,
    parameter int                  DATA_W    = 32,
    parameter logic [ADDR_W-1:0]   MSIX_ADDR = 'h1,
    parameter logic [DATA_W-1:0]   MSIX_DATA = 'h12345678,
    localparam int                 IW        = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ-1:0]        i_req_write,
    input  logic [NUM_REQ-1:0]        i_req_last,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_mem_valid,
    input  logic                      i_mem_ready,
    output logic                      o_mem_write,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    output logic [IW-1:0]             o_mem_id,
    input  logic                      i_mem_rvalid,
    input  logic [IW-1:0]             i_mem_rid,
    input  logic [DATA_W-1:0]         i_mem_rdata,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    input  logic                      i_msix_clr,
    output logic                      o_msix_intr,
    output logic [15:0]               o_msix_count
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_rr_ptr;
    logic                r_msix_intr;
    logic [15:0]         r_msix_count;

    logic                w_any;
    logic [IW-1:0]       w_pick;
    logic [IW-1:0]       w_owner_inc;
    logic                w_own_valid;
    logic                w_own_write;
    logic                w_own_last;
    logic [ADDR_W-1:0]   w_own_addr;
    logic [DATA_W-1:0]   w_own_wdata;
    logic                w_beat_acc;
    logic                w_doorbell;

    // Round-robin pick: first valid requester at or above r_rr_ptr, wrapping; scan from the far end so the nearest wins.
    always_comb begin
        int idx;
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (i_req_valid[idx[IW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = idx[IW-1:0];
            end
        end
    end

    // Select the owner's beat fields.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_write = 1'b0;
        w_own_last  = 1'b0;
        w_own_addr  = '0;
        w_own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_valid = i_req_valid[i];
                w_own_write = i_req_write[i];
                w_own_last  = i_req_last[i];
                w_own_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                w_own_wdata = i_req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_owner_inc = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);

    // FSM next-state and memory-port outputs; nothing is presented while IDLE.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_mem_valid = 1'b0;
        o_mem_write = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_id    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                o_mem_valid = w_own_valid;
                o_mem_write = w_own_write;
                o_mem_addr  = w_own_addr;
                o_mem_wdata = w_own_wdata;
                o_mem_id    = r_owner;
                for (int i = 0; i < NUM_REQ; i++) begin
                    o_req_ready[i] = i_mem_ready && (r_owner == IW'(i));
                end
                if (w_own_valid && i_mem_ready && w_own_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_beat_acc = o_mem_valid & i_mem_ready;
    assign w_doorbell = w_beat_acc & o_mem_write &
                        (o_mem_addr == MSIX_ADDR) & (o_mem_wdata == MSIX_DATA);

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Latch the winner on grant; advance the priority pointer past the owner when its burst ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_owner <= w_pick;
            end
            if (r_state == ST_LOCKED && w_beat_acc && w_own_last) begin
                r_rr_ptr <= w_owner_inc;
            end
        end
    end

    // MSI-X snoop: a doorbell sets the sticky flag (beating a simultaneous clear) and bumps the wrapping counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_msix_intr  <= 1'b0;
            r_msix_count <= '0;
        end else begin
            if (w_doorbell)      r_msix_intr <= 1'b1;
            else if (i_msix_clr) r_msix_intr <= 1'b0;
            if (w_doorbell)      r_msix_count <= r_msix_count + 16'd1;
        end
    end

    // Route read returns by id; an id with no matching requester produces no rsp_valid.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_rsp_valid[i] = i_mem_rvalid && (i_mem_rid == IW'(i));
        end
    end

    assign o_rsp_data   = i_mem_rdata;
    assign o_msix_intr  = r_msix_intr;
    assign o_msix_count = r_msix_count;

endmodule

// File: tb/tb_host_mem_arb.sv
// Directed bench for host_mem_arb: reset/idle, single beat, fairness, burst lock, read routing, MSI-X, reset mid-burst.
// Inputs driven 1 time unit after the rising edge; outputs sampled at least 1 unit after the last input change.
// A second 3-requester instance covers the out-of-range read-id case.
module tb_host_mem_arb;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid, req_write, req_last, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            mem_valid, mem_ready, mem_write, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata, rsp_data;
    logic [IW-1:0]   mem_id, mem_rid;
    logic [N-1:0]    rsp_valid;
    logic            msix_clr, msix_intr;
    logic [15:0]     msix_count;

    logic [2:0]      t3_req_valid, t3_req_ready, t3_rsp_valid;
    logic [3*AW-1:0] t3_req_addr;
    logic [3*DW-1:0] t3_req_wdata;
    logic            t3_mem_valid, t3_mem_write, t3_rvalid, t3_msix_intr;
    logic [AW-1:0]   t3_mem_addr;
    logic [DW-1:0]   t3_mem_wdata, t3_rsp_data;
    logic [1:0]      t3_mem_id, t3_rid;
    logic [15:0]     t3_msix_count;

    host_mem_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_write(req_write), .i_req_last(req_last),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_req_ready(req_ready),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_write(mem_write),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_id(mem_id),
        .i_mem_rvalid(mem_rvalid), .i_mem_rid(mem_rid), .i_mem_rdata(mem_rdata),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .i_msix_clr(msix_clr), .o_msix_intr(msix_intr), .o_msix_count(msix_count)
    );

    host_mem_arb #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(t3_req_valid), .i_req_write(3'b000), .i_req_last(3'b000),
        .i_req_addr(t3_req_addr), .i_req_wdata(t3_req_wdata), .o_req_ready(t3_req_ready),
        .o_mem_valid(t3_mem_valid), .i_mem_ready(1'b0), .o_mem_write(t3_mem_write),
        .o_mem_addr(t3_mem_addr), .o_mem_wdata(t3_mem_wdata), .o_mem_id(t3_mem_id),
        .i_mem_rvalid(t3_rvalid), .i_mem_rid(t3_rid), .i_mem_rdata(32'h0BADF00D),
        .o_rsp_valid(t3_rsp_valid), .o_rsp_data(t3_rsp_data),
        .i_msix_clr(1'b0), .o_msix_intr(t3_msix_intr), .o_msix_count(t3_msix_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input logic l,
                           input logic [63:0] a, input logic [31:0] d);
        req_valid[i]            = v;
        req_write[i]            = w;
        req_last[i]             = l;
        req_addr[i*AW +: AW]    = a;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    endtask

    // Single-beat transaction from requester idx, starting in IDLE; returns in the IDLE cycle after acceptance.
    task automatic single(input int idx, input logic w, input logic [63:0] a,
                          input logic [31:0] d, input logic clr);
        set_req(idx, 1'b1, w, 1'b1, a, d);
        mem_ready = 1'b1;
        #1;
        chk("sb_idle_mv", mem_valid, 0);
        step();
        chk("sb_mv", mem_valid, 1);
        chk("sb_id", mem_id, idx);
        msix_clr = clr;
        step();
        set_req(idx, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        msix_clr = 1'b0;
        #1;
    endtask

    int         beat [N];
    int         b;
    int         ph;
    logic       mr;
    logic [N-1:0] acc;

    initial begin
        rst = 1'b1;
        clear_reqs();
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rid = '0; mem_rdata = '0; msix_clr = 1'b0;
        t3_req_valid = '0; t3_req_addr = '0; t3_req_wdata = '0; t3_rvalid = 1'b0; t3_rid = '0;
        step(); step();
        rst = 1'b0;

        // Reset state and idle outputs.
        for (int c = 0; c < 10; c++) begin
            chk("idle_outs", {req_ready, mem_valid, rsp_valid, msix_intr, msix_count}, 0);
            step();
        end

        // Single write beat from requester 0.
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h100, 32'hA5);
        mem_ready = 1'b1;
        #1;
        chk("t1_nomv", mem_valid, 0);
        step();
        chk("t1_mv", mem_valid, 1);
        chk("t1_id", mem_id, 0);
        chk("t1_rdy", req_ready, 4'b0001);
        chk("t1_addr", mem_addr, 64'h100);
        chk("t1_wdata", mem_wdata, 32'hA5);
        chk("t1_write", mem_write, 1);
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk("t1_rdy_off", req_ready, 4'b0000);
        chk("t1_mv_off", mem_valid, 0);

        // Fairness: reset pointer, all requesters stream 2-beat bursts.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) beat[i] = 0;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'b1, 1'b1, beat[i] == 1, 64'(i * 'h1000 + beat[i] * 4),
                        32'hF000_0000 | 32'(i << 8) | 32'(beat[i]));
            mem_ready = 1'b1;
            #1;
            ph = k % 3;
            if (ph == 0) begin
                chk("fair_gap", mem_valid, 0);
            end else begin
                chk("fair_vld", mem_valid, 1);
                chk("fair_id", mem_id, (k / 3) % 4);
                chk("fair_addr", mem_addr, ((k / 3) % 4) * 'h1000 + (ph - 1) * 4);
            end
            acc = req_ready & req_valid;
            step();
            for (int i = 0; i < N; i++)
                if (acc[i]) beat[i] = (beat[i] == 1) ? 0 : beat[i] + 1;
        end

        // Burst lock with backpressure: requester 2 (4 beats) vs pending requester 0; pointer is now 1.
        clear_reqs();
        b = 0;
        set_req(2, 1'b1, 1'b1, 1'b0, 64'h2000, 32'hC0DE0000);
        set_req(0, 1'b1, 1'b1, 1'b1, 64'h40, 32'h0000BEEF);
        #1;
        chk("bl_idle", mem_valid, 0);
        step();
        for (int j = 0; j < 7; j++) begin
            mr = (j % 2 == 0);
            mem_ready = mr;
            set_req(2, 1'b1, 1'b1, b == 3, 64'(64'h2000 + b * 4), 32'hC0DE0000 + 32'(b));
            #1;
            chk("bl_vld", mem_valid, 1);
            chk("bl_id", mem_id, 2);
            chk("bl_addr", mem_addr, 64'h2000 + b * 4);
            chk("bl_wdata", mem_wdata, 32'hC0DE0000 + b);
            chk("bl_rdy2", req_ready[2], mr);
            chk("bl_rdy0", req_ready[0], 0);
            step();
            if (mr) b++;
        end
        set_req(2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        mem_ready = 1'b1;
        #1;
        chk("bl_gap", mem_valid, 0);
        step();
        chk("bl_r0_vld", mem_valid, 1);
        chk("bl_r0_id", mem_id, 0);
        chk("bl_r0_addr", mem_addr, 64'h40);
        chk("bl_r0_rdy", req_ready, 4'b0001);
        step();
        clear_reqs();

        // Read routing.
        mem_rvalid = 1'b1; mem_rid = 2'd3; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_vld3", rsp_valid, 4'b1000);
        chk("rd_data", rsp_data, 32'hDEADBEEF);
        mem_rid = 2'd0;
        #1;
        chk("rd_vld0", rsp_valid, 4'b0001);
        mem_rvalid = 1'b0;
        #1;
        chk("rd_none", rsp_valid, 4'b0000);
        t3_rvalid = 1'b1; t3_rid = 2'd3;
        #1;
        chk("rd_oor", t3_rsp_valid, 3'b000);
        t3_rid = 2'd2;
        #1;
        chk("rd_n3_2", t3_rsp_valid, 3'b100);
        t3_rvalid = 1'b0;
        step();

        // MSI-X snoop.
        chk("mx_intr0", msix_intr, 0);
        chk("mx_cnt0", msix_count, 0);
        single(1, 1'b1, 64'h1, 32'h12345678, 1'b0);
        chk("mx_intr1", msix_intr, 1);
        chk("mx_cnt1", msix_count, 1);
        single(2, 1'b1, 64'h1, 32'h12345679, 1'b0);
        chk("mx_baddata_intr", msix_intr, 1);
        chk("mx_baddata_cnt", msix_count, 1);
        single(3, 1'b0, 64'h1, 32'h12345678, 1'b0);
        chk("mx_read_cnt", msix_count, 1);
        single(0, 1'b1, 64'h1, 32'h12345678, 1'b1);
        chk("mx_setwins", msix_intr, 1);
        chk("mx_cnt2", msix_count, 2);
        msix_clr = 1'b1;
        step();
        msix_clr = 1'b0;
        chk("mx_clr", msix_intr, 0);
        chk("mx_clr_cnt", msix_count, 2);

        // Reset mid-burst from requester 1 (pointer is 1 before reset).
        set_req(1, 1'b1, 1'b1, 1'b0, 64'h3000, 32'h11);
        mem_ready = 1'b1;
        step();
        chk("rm_id", mem_id, 1);
        step();
        set_req(1, 1'b1, 1'b1, 1'b0, 64'h3004, 32'h12);
        rst = 1'b1;
        #1;
        chk("rm_beat2", mem_addr, 64'h3004);
        step();
        rst = 1'b0;
        clear_reqs();
        #1;
        chk("rm_mv", mem_valid, 0);
        chk("rm_rdy", req_ready, 4'b0000);
        chk("rm_cnt", msix_count, 0);
        chk("rm_intr", msix_intr, 0);
        set_req(0, 1'b1, 1'b0, 1'b1, 64'h4000, 32'h0);
        set_req(3, 1'b1, 1'b1, 1'b1, 64'h5000, 32'h33);
        step();
        chk("rm_ptr0", mem_id, 0);
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        #1;
        chk("rm_gap", mem_valid, 0);
        step();
        chk("rm_r3_vld", mem_valid, 1);
        chk("rm_r3_id", mem_id, 3);
        chk("rm_r3_addr", mem_addr, 64'h5000);
        chk("rm_r3_rdy", req_ready, 4'b1000);
        step();
        clear_reqs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
